// File: rtl/bus_arbiter.sv
// Shared-bus arbiter: master has fixed priority and CiMs rotate round-robin.
// Each granted beat is registered onto the bus, with a one-cycle gap between tenures.
module bus_arbiter #(
  parameter int NUM_REQ = 8,
  parameter int DATA_W  = 22,
  parameter int OP_W    = 4,
  parameter int TIMEOUT = 16
) (
  input  logic                                i_gclk,
  input  logic                                i_grst_n,
  input  logic [NUM_REQ-1:0]                  i_req,
  input  logic [NUM_REQ-1:0]                  i_beat_valid,
  input  logic [NUM_REQ-1:0]                  i_beat_last,
  input  logic [NUM_REQ*OP_W-1:0]             i_beat_op,
  input  logic [NUM_REQ*DATA_W-1:0]           i_beat_data,
  input  logic [NUM_REQ*$clog2(NUM_REQ)-1:0]  i_beat_target,
  output logic [NUM_REQ-1:0]                  o_gnt,
  output logic [OP_W-1:0]                     o_bus_op,
  output logic [DATA_W-1:0]                   o_bus_data,
  output logic [$clog2(NUM_REQ)-1:0]          o_bus_target_or_sender,
  output logic [$clog2(NUM_REQ)-1:0]          o_bus_sender,
  output logic                                o_timeout_err
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  typedef enum logic [1:0] {S_IDLE, S_OWN, S_GAP} state_t;

  state_t                 r_state;
  logic [NUM_REQ-1:0]     r_gnt;
  logic [IW-1:0]          r_owner;
  logic [IW-1:0]          r_rr_ptr;
  logic [CW-1:0]          r_idle;
  logic [OP_W-1:0]        r_bus_op;
  logic [DATA_W-1:0]      r_bus_data;
  logic [IW-1:0]          r_bus_tgt;
  logic [IW-1:0]          r_bus_sender;
  logic                   r_timeout_err;

  logic [NUM_REQ-1:0][OP_W-1:0]   w_op;
  logic [NUM_REQ-1:0][DATA_W-1:0] w_data;
  logic [NUM_REQ-1:0][IW-1:0]     w_tgt;
  logic                           w_win_found;
  logic [IW-1:0]                  w_win_idx;
  logic [IW-1:0]                  w_rr_next;
  logic [IW:0]                    w_cand;

  assign w_op   = i_beat_op;
  assign w_data = i_beat_data;
  assign w_tgt  = i_beat_target;

  // CiM search wraps over 1..NUM_REQ-1 only; index 0 is handled by priority.
  always_comb begin
    w_win_found = 1'b0;
    w_win_idx   = '0;
    w_cand      = '0;
    if (i_req[0]) begin
      w_win_found = 1'b1;
    end else begin
      for (int k = 0; k < NUM_REQ-1; k++) begin
        w_cand = {1'b0, r_rr_ptr} + (IW+1)'(k);
        if (w_cand > (IW+1)'(NUM_REQ-1)) w_cand = w_cand - (IW+1)'(NUM_REQ-1);
        if (!w_win_found && i_req[w_cand[IW-1:0]]) begin
          w_win_found = 1'b1;
          w_win_idx   = w_cand[IW-1:0];
        end
      end
    end
  end

  assign w_rr_next = (r_owner == IW'(NUM_REQ-1)) ? IW'(1) : r_owner + IW'(1);

  always_ff @(posedge i_gclk) begin
    if (!i_grst_n) begin
      r_state       <= S_IDLE;
      r_gnt         <= '0;
      r_owner       <= '0;
      r_rr_ptr      <= IW'(1);
      r_idle        <= '0;
      r_bus_op      <= '0;
      r_bus_data    <= '0;
      r_bus_tgt     <= '0;
      r_bus_sender  <= '0;
      r_timeout_err <= 1'b0;
    end else begin
      r_timeout_err <= 1'b0;
      r_bus_op      <= '0;
      unique case (r_state)
        S_IDLE: begin
          if (w_win_found) begin
            r_gnt   <= NUM_REQ'(1) << w_win_idx;
            r_owner <= w_win_idx;
            r_idle  <= '0;
            r_state <= S_OWN;
          end
        end
        S_OWN: begin
          if (i_beat_valid[r_owner]) begin
            r_bus_op     <= w_op[r_owner];
            r_bus_data   <= w_data[r_owner];
            r_bus_tgt    <= w_tgt[r_owner];
            r_bus_sender <= r_owner;
            r_idle       <= '0;
            if (i_beat_last[r_owner]) begin
              r_gnt   <= '0;
              r_state <= S_GAP;
              if (r_owner != '0) r_rr_ptr <= w_rr_next;
            end
          end else if (!i_req[r_owner] || r_idle == CW'(TIMEOUT-1)) begin
            // stalled or abandoned tenure: revoke without driving a beat
            r_gnt         <= '0;
            r_timeout_err <= 1'b1;
            r_state       <= S_GAP;
            if (r_owner != '0) r_rr_ptr <= w_rr_next;
          end else begin
            r_idle <= r_idle + CW'(1);
          end
        end
        S_GAP:   r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_gnt                  = r_gnt;
  assign o_bus_op               = r_bus_op;
  assign o_bus_data             = r_bus_data;
  assign o_bus_target_or_sender = r_bus_tgt;
  assign o_bus_sender           = r_bus_sender;
  assign o_timeout_err          = r_timeout_err;
endmodule

// File: tb/tb_bus_arbiter.sv
// Directed bench for bus_arbiter: table of tenures plus hand-written corner sequences.
module tb_bus_arbiter;
  localparam int N = 8, DW = 22, OW = 4, IW = 3;

  logic              clk = 1'b0;
  logic              rst_n = 1'b0;
  logic [N-1:0]      req = '0, bv = '0, bl = '0;
  logic [N*OW-1:0]   bop = '0;
  logic [N*DW-1:0]   bdata = '0;
  logic [N*IW-1:0]   btgt = '0;
  logic [N-1:0]      gnt;
  logic [OW-1:0]     bus_op;
  logic [DW-1:0]     bus_data;
  logic [IW-1:0]     bus_tgt, bus_sender;
  logic              terr;

  int checks = 0, failures = 0;

  bus_arbiter #(.NUM_REQ(N), .DATA_W(DW), .OP_W(OW), .TIMEOUT(16)) dut (
    .i_gclk(clk), .i_grst_n(rst_n), .i_req(req), .i_beat_valid(bv), .i_beat_last(bl),
    .i_beat_op(bop), .i_beat_data(bdata), .i_beat_target(btgt),
    .o_gnt(gnt), .o_bus_op(bus_op), .o_bus_data(bus_data),
    .o_bus_target_or_sender(bus_tgt), .o_bus_sender(bus_sender), .o_timeout_err(terr)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          pre_rst;
    logic [N-1:0]  req;
    int            idx;
    int            nb;
    logic [OW-1:0] op;
    logic [DW-1:0] data;
    logic [IW-1:0] tgt;
  } vec_t;

  vec_t tbl[6];

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
    end
  endtask

  task automatic set_beat(input int i, input logic v, input logic l, input logic [OW-1:0] op,
                          input logic [DW-1:0] d, input logic [IW-1:0] t);
    bv[i] = v; bl[i] = l;
    bop[i*OW +: OW] = op; bdata[i*DW +: DW] = d; btgt[i*IW +: IW] = t;
  endtask

  task automatic wait_gnt(input int max, output int n);
    n = 0;
    while (n < max && gnt == '0) begin tick(); n++; end
  endtask

  // Owner idx sends nb beats; bus, grant drop and the NOP gap cycle are checked.
  task automatic tenure(input int idx, input int nb, input logic [OW-1:0] op, input logic [DW-1:0] d,
                        input logic [IW-1:0] t, input int exp_wait, input logic [N-1:0] mid_req,
                        input logic rel);
    int n;
    logic [N-1:0] oh;
    oh = N'(1) << idx;
    wait_gnt(20, n);
    chk("gnt_wait", n, exp_wait);
    chk("gnt_owner", gnt, oh);
    req = req | mid_req;
    for (int b = 0; b < nb; b++) begin
      set_beat(idx, 1'b1, b == nb-1, op, d + DW'(b), t);
      if (b == nb-1 && rel) req[idx] = 1'b0;
      tick();
      chk("beat_op", bus_op, op);
      chk("beat_data", bus_data, d + DW'(b));
      chk("beat_tgt", bus_tgt, t);
      chk("beat_sender", bus_sender, idx);
      chk("beat_gnt", gnt, (b == nb-1) ? '0 : oh);
    end
    set_beat(idx, 1'b0, 1'b0, '0, '0, '0);
    tick();
    chk("gap_op", bus_op, 0);
    chk("gap_gnt", gnt, 0);
    chk("hold_data", bus_data, d + DW'(nb-1));
    chk("hold_sender", bus_sender, idx);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    tbl[0] = '{1'b0, 8'h08,        3, 3, 4'd2, 22'h0000A1, 3'd5};
    tbl[1] = '{1'b1, 8'b0011_0110, 1, 1, 4'd1, 22'h000101, 3'd0};
    tbl[2] = '{1'b0, 8'b0011_0110, 2, 1, 4'd1, 22'h000102, 3'd1};
    tbl[3] = '{1'b0, 8'b0011_0110, 4, 1, 4'd1, 22'h000104, 3'd2};
    tbl[4] = '{1'b0, 8'b0011_0110, 5, 1, 4'd1, 22'h000105, 3'd3};
    tbl[5] = '{1'b0, 8'b0011_0110, 1, 1, 4'd1, 22'h000111, 3'd4};

    // reset held with every input asserted
    rst_n = 1'b0; req = '1; bv = '1; bl = '1; bop = '1; bdata = '1; btgt = '1;
    for (int i = 0; i < 4; i++) begin
      tick();
      chk("rst_gnt", gnt, 0);
      chk("rst_op", bus_op, 0);
      chk("rst_terr", terr, 0);
    end
    rst_n = 1'b1; req = '0; bv = '0; bl = '0; bop = '0; bdata = '0; btgt = '0;
    tick();
    chk("rel_gnt0", gnt, 0);
    req = 8'h04;
    tick();
    chk("rel_gnt", gnt, 8'h04);
    set_beat(2, 1'b1, 1'b1, 4'd1, 22'h000111, 3'd0);
    req = '0;
    tick();
    chk("rel_beat_op", bus_op, 1);
    chk("rel_beat_sender", bus_sender, 2);
    chk("rel_beat_gnt", gnt, 0);
    set_beat(2, 1'b0, 1'b0, '0, '0, '0);
    tick();
    chk("rel_nop", bus_op, 0);

    // table: CiM 3 burst, then round-robin from a fresh pointer
    foreach (tbl[i]) begin
      if (tbl[i].pre_rst) begin
        req = '0; rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
      end
      req = tbl[i].req;
      tenure(tbl[i].idx, tbl[i].nb, tbl[i].op, tbl[i].data, tbl[i].tgt, 1, '0, 1'b0);
    end
    req = '0;
    tick();

    // CiM 2 not preempted by master; master then beats pending CiM 6; CiM 6 beats CiM 1
    req = 8'h04;
    tenure(2, 3, 4'd3, 22'h000200, 3'd1, 1, 8'h41, 1'b1);
    tenure(0, 1, 4'd4, 22'h000300, 3'd6, 1, 8'h02, 1'b1);
    tenure(6, 1, 4'd5, 22'h000310, 3'd0, 1, 8'h00, 1'b1);
    req = '0;

    // owner drops req without a last beat
    req = 8'h20;
    wait_gnt(20, n);
    chk("drop_gnt", gnt, 8'h20);
    req = '0;
    tick();
    chk("drop_revoke", gnt, 0);
    chk("drop_terr", terr, 1);
    chk("drop_op", bus_op, 0);
    tick();
    chk("drop_terr_once", terr, 0);

    // CiM 7 stalls for the full timeout while non-owner CiM 3 strobes beats
    req = 8'h80;
    wait_gnt(20, n);
    chk("to_wait", n, 1);
    chk("to_gnt", gnt, 8'h80);
    set_beat(3, 1'b1, 1'b1, 4'd7, 22'h3FFFFF, 3'd7);
    for (int i = 1; i <= 16; i++) begin
      tick();
      chk("to_op", bus_op, 0);
      chk("to_gnt_i", gnt, (i < 16) ? 8'h80 : 8'h00);
      chk("to_terr_i", terr, (i < 16) ? 0 : 1);
    end
    set_beat(3, 1'b0, 1'b0, '0, '0, '0);
    req = '0;
    tick();
    chk("to_terr_once", terr, 0);
    chk("to_op_after", bus_op, 0);
    req = 8'h06;
    tenure(1, 1, 4'd6, 22'h000500, 3'd3, 1, 8'h00, 1'b1);
    req = '0;
    tick();

    // reset during the second beat of a 4-beat CiM 1 tenure
    req = 8'h02;
    wait_gnt(20, n);
    chk("mr_gnt", gnt, 8'h02);
    set_beat(1, 1'b1, 1'b0, 4'd5, 22'h000401, 3'd2);
    tick();
    chk("mr_beat1_op", bus_op, 5);
    chk("mr_beat1_data", bus_data, 22'h000401);
    set_beat(1, 1'b1, 1'b0, 4'd5, 22'h000402, 3'd2);
    rst_n = 1'b0;
    tick();
    chk("mr_gnt0", gnt, 0);
    chk("mr_op0", bus_op, 0);
    chk("mr_data0", bus_data, 0);
    chk("mr_tgt0", bus_tgt, 0);
    chk("mr_sender0", bus_sender, 0);
    chk("mr_terr0", terr, 0);
    rst_n = 1'b1; req = '0;
    for (int i = 0; i < 3; i++) begin
      set_beat(1, 1'b1, i == 1, 4'd5, 22'h000403 + DW'(i), 3'd2);
      tick();
      chk("mr_no_beat_op", bus_op, 0);
      chk("mr_no_beat_data", bus_data, 0);
      chk("mr_no_gnt", gnt, 0);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
